// File: rtl/sid_pkg.sv
// Shared types and default timing constants for the SID voice/filter scheduler.
package sid;

   localparam int unsigned CYCLE_W  = 5;
   localparam int unsigned FCYCLE_W = 4;
   localparam int unsigned US_W     = 10;
   localparam int unsigned CNT_W    = 8;

   typedef logic [CYCLE_W-1:0]  cycle_t;
   typedef logic [FCYCLE_W-1:0] fcycle_t;

   localparam cycle_t  VOICE_LAST_CYCLE   = CYCLE_W'(18);
   localparam cycle_t  FILTER_START_CYCLE = CYCLE_W'(6);
   localparam fcycle_t FILTER_IDLE_A      = FCYCLE_W'(4);
   localparam fcycle_t FILTER_IDLE_B      = FCYCLE_W'(5);

   // Saturating increment for the overrun counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sid_ms_tick.sv
// Frame counter producing the ~1 kHz tick: one count per frame start, tick at the top count.
module sid_ms_tick
   import sid::*;
(
   input  logic clk,
   input  logic res_n,
   input  logic adv,
   output logic tick_ms
);

   logic [US_W-1:0] count_us;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         count_us <= '0;
      end else if (adv) begin
         count_us <= count_us + US_W'(1);
      end
   end

   assign tick_ms = (count_us == '1);

endmodule

// File: rtl/sid_sched.sv
// SID pipeline scheduler: voice and filter cycle counters restarted by phi2 falls,
// with overrun detection for falls that land mid-frame.
module sid_sched
   import sid::*;
#(
   parameter cycle_t  VOICE_LAST   = VOICE_LAST_CYCLE,
   parameter cycle_t  FILTER_START = FILTER_START_CYCLE,
   parameter fcycle_t IDLE_A       = FILTER_IDLE_A,
   parameter fcycle_t IDLE_B       = FILTER_IDLE_B
)
(
   input  logic             clk,
   input  logic             res_n,
   input  logic             phi2,
   input  logic             ovr_clr,
   output cycle_t           voice_cycle,
   output fcycle_t          filter_cycle,
   output logic             voice_idle,
   output logic             frame_start,
   output logic             tick_ms,
   output logic             overrun,
   output logic [CNT_W-1:0] ovr_cnt
);

   logic   phi2_prev;
   logic   fall;
   logic   ovr_event;
   logic   frame_adv;
   cycle_t vcount;

   assign fall        = phi2_prev & ~phi2;
   assign voice_idle  = (filter_cycle == IDLE_A) || (filter_cycle == IDLE_B);
   assign voice_cycle = voice_idle ? '0 : vcount;
   assign frame_adv   = (voice_cycle == CYCLE_W'(1));
   // A restart is only legal while idle or on the last voice cycle.
   assign ovr_event   = fall && (vcount != '0) && (vcount != VOICE_LAST);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         phi2_prev   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         phi2_prev   <= phi2;
         frame_start <= fall;
      end
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         vcount <= '0;
      end else if (fall) begin
         vcount <= CYCLE_W'(1);
      end else if (vcount == VOICE_LAST) begin
         vcount <= '0;
      end else if ((vcount != '0) && !voice_idle) begin
         vcount <= vcount + CYCLE_W'(1);
      end
   end

   // Filter pipeline free-runs once started and stops only after wrapping to 0.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         filter_cycle <= '0;
      end else if ((voice_cycle == FILTER_START) || (filter_cycle != '0)) begin
         filter_cycle <= filter_cycle + FCYCLE_W'(1);
      end
   end

   // Clear takes effect first, so a simultaneous event leaves a count of one.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         overrun <= 1'b0;
         ovr_cnt <= '0;
      end else if (ovr_event) begin
         overrun <= 1'b1;
         ovr_cnt <= ovr_clr ? CNT_W'(1) : sat_inc(ovr_cnt);
      end else if (ovr_clr) begin
         overrun <= 1'b0;
         ovr_cnt <= '0;
      end
   end

   sid_ms_tick u_ms_tick (
      .clk     (clk),
      .res_n   (res_n),
      .adv     (frame_adv),
      .tick_ms (tick_ms)
   );

endmodule

// File: tb/tb_sid_sched.sv
// Directed bench for sid_sched; expectations are queued with a target cycle and checked when reached.
module tb_sid_sched;
   import sid::*;

   logic       clk     = 1'b0;
   logic       res_n   = 1'b0;
   logic       phi2    = 1'b0;
   logic       ovr_clr = 1'b0;
   cycle_t     voice_cycle;
   fcycle_t    filter_cycle;
   logic       voice_idle;
   logic       frame_start;
   logic       tick_ms;
   logic       overrun;
   logic [7:0] ovr_cnt;

   typedef enum int {S_VC, S_FC, S_VI, S_FS, S_TICK, S_OV, S_CNT} sig_e;
   typedef struct {
      int          at;
      sig_e        sig;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   cyc_no = 0;
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;

   sid_sched dut (
      .clk          (clk),
      .res_n        (res_n),
      .phi2         (phi2),
      .ovr_clr      (ovr_clr),
      .voice_cycle  (voice_cycle),
      .filter_cycle (filter_cycle),
      .voice_idle   (voice_idle),
      .frame_start  (frame_start),
      .tick_ms      (tick_ms),
      .overrun      (overrun),
      .ovr_cnt      (ovr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] obs(input sig_e s);
      case (s)
         S_VC:    return 32'(voice_cycle);
         S_FC:    return 32'(filter_cycle);
         S_VI:    return 32'(voice_idle);
         S_FS:    return 32'(frame_start);
         S_TICK:  return 32'(tick_ms);
         S_OV:    return 32'(overrun);
         S_CNT:   return 32'(ovr_cnt);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic push(input int at, input sig_e s, input int v, input string tag);
      exp_t e;
      e.at  = at;
      e.sig = s;
      e.val = 32'(v);
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic push_all_zero(input int at, input string tag);
      push(at, S_VC, 0, {tag, "_vc"});
      push(at, S_FC, 0, {tag, "_fc"});
      push(at, S_VI, 0, {tag, "_vi"});
      push(at, S_FS, 0, {tag, "_fs"});
      push(at, S_TICK, 0, {tag, "_tick"});
      push(at, S_OV, 0, {tag, "_ov"});
      push(at, S_CNT, 0, {tag, "_cnt"});
   endtask

   // Expected frame from an idle start with the fall in cycle e (offset n = 0).
   task automatic push_frame(input int e, input int last, input string tag);
      for (int n = 0; n <= last; n++) begin
         int vc;
         int fc;
         vc = (n >= 1 && n <= 9) ? n : ((n >= 12 && n <= 20) ? n - 2 : 0);
         fc = (n >= 7 && n <= 21) ? n - 6 : 0;
         push(e + n, S_VC, vc, {tag, "_vc"});
         push(e + n, S_FC, fc, {tag, "_fc"});
         push(e + n, S_FS, (n == 1) ? 1 : 0, {tag, "_fs"});
         push(e + n, S_VI, (fc == 4 || fc == 5) ? 1 : 0, {tag, "_vi"});
      end
   endtask

   task automatic sample();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc_no) begin
            logic [31:0] o;
            o = obs(sb[i].sig);
            checks++;
            assert (o === sb[i].val) passed++;
            else begin
               fails++;
               $error("FAIL %s cycle %0d: observed %0d expected %0d",
                      sb[i].tag, cyc_no, o, sb[i].val);
            end
            sb.delete(i);
         end
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled 3 units later.
   task automatic cyc(input int n);
      repeat (n) begin
         #3;
         sample();
         @(posedge clk);
         #1;
         cyc_no++;
      end
   endtask

   initial begin
      int e;
      int f;
      @(posedge clk);
      #1;

      // reset state
      push_all_zero(cyc_no, "reset");
      cyc(1);
      res_n = 1'b1;
      phi2  = 1'b1;
      cyc(2);

      // single frame from idle
      e = cyc_no;
      phi2 = 1'b0;
      push_frame(e, 24, "f1");
      cyc(25);

      // reset pulse mid-frame, then a clean frame
      phi2 = 1'b1;
      cyc(1);
      e = cyc_no;
      phi2 = 1'b0;
      push_frame(e, 8, "pre_rst");
      cyc(9);
      res_n = 1'b0;
      push_all_zero(cyc_no, "mid_rst");
      cyc(1);
      res_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push(cyc_no + k, S_VC, 0, "post_rst_vc");
         push(cyc_no + k, S_FC, 0, "post_rst_fc");
      end
      cyc(5);
      phi2 = 1'b1;
      cyc(1);
      e = cyc_no;
      phi2 = 1'b0;
      push_frame(e, 24, "f_after_rst");
      cyc(25);

      // legal back-to-back fall on the last voice cycle
      phi2 = 1'b1;
      cyc(1);
      e = cyc_no;
      phi2 = 1'b0;
      push_frame(e, 18, "f_legal");
      cyc(19);
      push(e + 20, S_VC, 18, "legal_vc18");
      push(e + 20, S_OV, 0, "legal_ov_pre");
      push(e + 21, S_VC, 1, "legal_vc1");
      push(e + 21, S_FS, 1, "legal_fs");
      push(e + 21, S_FC, 15, "legal_fc15");
      push(e + 21, S_OV, 0, "legal_ov");
      push(e + 22, S_VC, 2, "legal_vc2");
      push(e + 22, S_FC, 0, "legal_fc0");
      phi2 = 1'b1;
      cyc(1);
      phi2 = 1'b0;
      cyc(3);
      cyc(25);

      // mid-frame fall raises overrun and restarts the voice counter
      phi2 = 1'b1;
      cyc(1);
      e = cyc_no;
      phi2 = 1'b0;
      cyc(14);
      phi2 = 1'b1;
      cyc(1);
      phi2 = 1'b0;
      push(e + 15, S_VC, 13, "ovr_vc13");
      push(e + 15, S_OV, 0, "ovr_ov_pre");
      push(e + 16, S_OV, 1, "ovr_ov");
      push(e + 16, S_CNT, 1, "ovr_cnt1");
      push(e + 16, S_VC, 1, "ovr_vc1");
      cyc(2);

      // repeated overruns saturate the counter
      for (int i = 2; i <= 300; i++) begin
         phi2 = 1'b1;
         cyc(2);
         phi2 = 1'b0;
         if (i == 254 || i == 255 || i == 256 || i == 300) begin
            push(cyc_no, S_CNT, (i - 1 > 255) ? 255 : i - 1, "sat_before");
            push(cyc_no + 1, S_CNT, (i > 255) ? 255 : i, "sat_after");
         end
         cyc(3);
      end

      // clear coinciding with an event, then a clear alone
      phi2 = 1'b1;
      cyc(1);
      phi2    = 1'b0;
      ovr_clr = 1'b1;
      push(cyc_no, S_CNT, 255, "clr_ev_before");
      push(cyc_no + 1, S_OV, 1, "clr_ev_ov");
      push(cyc_no + 1, S_CNT, 1, "clr_ev_cnt");
      cyc(1);
      ovr_clr = 1'b0;
      cyc(1);
      ovr_clr = 1'b1;
      push(cyc_no + 1, S_OV, 0, "clr_ov");
      push(cyc_no + 1, S_CNT, 0, "clr_cnt");
      cyc(1);
      ovr_clr = 1'b0;
      cyc(1);

      // millisecond tick across 1024 frames
      res_n = 1'b0;
      cyc(1);
      res_n = 1'b1;
      phi2  = 1'b1;
      cyc(1);
      for (int k = 1; k <= 1024; k++) begin
         f = cyc_no;
         phi2 = 1'b0;
         if (k == 1) begin
            push(f + 1, S_TICK, 0, "tick_first");
         end
         if (k == 1023) begin
            push(f + 1, S_TICK, 0, "tick_pre_rise");
            push(f + 2, S_TICK, 1, "tick_rise");
         end
         if (k == 1024) begin
            push(f + 1, S_TICK, 1, "tick_hold");
            push(f + 2, S_TICK, 0, "tick_fall");
         end
         cyc(21);
         phi2 = 1'b1;
         cyc(1);
      end
      cyc(2);

      checks++;
      assert (sb.size() == 0) passed++;
      else begin
         fails++;
         $error("FAIL sb_drain: observed %0d pending expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
